// File: rtl/hidden_cpu_driver.sv
// hidden_cpu_driver: stores a short program of 6-bit entries. On start, it
// replays the program onto an 8-bit CPU pin bus. The sequence is a CPU reset
// phase, then one CPU clock pulse per entry, and finally a capture of the
// CPU result bus.
// cpu_pins layout: [0] cpu clk, [1] cpu rst, [7:2] entry {reg1, reg0, opcode}.
module hidden_cpu_driver #(
   parameter int DEPTH = 16,
   parameter int HALF  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   input  logic [5:0]                 wr_data,
   output logic                       wr_ready,
   input  logic                       clear,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     prog_count,
   output logic [7:0]                 cpu_pins,
   input  logic [7:0]                 cpu_out,
   output logic [7:0]                 result,
   output logic                       result_valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [HW-1:0] LAST_C  = HW'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RST_CPU = 3'd1,
      SETUP   = 3'd2,
      CLK_HI  = 3'd3,
      CAPTURE = 3'd4
   } state_t;

   // Pin image for one program entry with the given CPU clock level
   // (CPU reset is always low while entries are being driven).
   function automatic logic [7:0] entry_pins(input logic [5:0] entry, input logic cpu_clk);
      entry_pins = {entry, 1'b0, cpu_clk};
   endfunction

   state_t          state_r, state_next_s;
   logic [HW-1:0]   cnt_r, cnt_next_s;
   logic [CW-1:0]   pc_r, pc_next_s, pc_inc_s;
   logic [CW-1:0]   count_r, count_next_s;
   logic [7:0]      pins_r, pins_next_s;
   logic [7:0]      result_r;
   logic            done_r, done_next_s;
   logic            rv_r, rv_next_s;
   logic            busy_r;
   logic            wr_ready_r;
   logic            wr_en_s;
   logic            capture_s;
   logic [5:0]      mem_r [DEPTH];

   assign wr_ready     = wr_ready_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign prog_count   = count_r;
   assign cpu_pins     = pins_r;
   assign result       = result_r;
   assign result_valid = rv_r;

   // Program store; contents survive clear and reset, only prog_count gates access.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[count_r[PW-1:0]] <= wr_data;
      end
   end

   // Next-state, next-output and write-accept decode. Output values are
   // computed from the next state so every output leaves a flop.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      pc_next_s    = pc_r;
      count_next_s = count_r;
      pins_next_s  = 8'h00;
      done_next_s  = 1'b0;
      rv_next_s    = 1'b0;
      wr_en_s      = 1'b0;
      capture_s    = 1'b0;
      pc_inc_s     = pc_r + CW'(1);

      case (state_r)
         IDLE: begin
            if (clear) begin
               // clear beats both a write and a start in the same cycle
               count_next_s = {CW{1'b0}};
            end else begin
               if (wr_valid && (count_r < DEPTH_C)) begin
                  wr_en_s      = 1'b1;
                  count_next_s = count_r + CW'(1);
               end else begin
                  count_next_s = count_r;
               end
               // a write accepted alongside start is part of the run
               if (start) begin
                  if (count_next_s == {CW{1'b0}}) begin
                     done_next_s = 1'b1;
                  end else begin
                     state_next_s = RST_CPU;
                     cnt_next_s   = {HW{1'b0}};
                     pins_next_s  = 8'h02;
                  end
               end else begin
                  state_next_s = IDLE;
               end
            end
         end

         RST_CPU: begin
            pins_next_s = 8'h02;
            if (cnt_r == LAST_C) begin
               state_next_s = SETUP;
               cnt_next_s   = {HW{1'b0}};
               pc_next_s    = {CW{1'b0}};
               pins_next_s  = entry_pins(mem_r[0], 1'b0);
            end else begin
               cnt_next_s = cnt_r + HW'(1);
            end
         end

         SETUP: begin
            pins_next_s = entry_pins(mem_r[pc_r[PW-1:0]], 1'b0);
            if (cnt_r == LAST_C) begin
               state_next_s = CLK_HI;
               cnt_next_s   = {HW{1'b0}};
               pins_next_s  = entry_pins(mem_r[pc_r[PW-1:0]], 1'b1);
            end else begin
               cnt_next_s = cnt_r + HW'(1);
            end
         end

         CLK_HI: begin
            pins_next_s = entry_pins(mem_r[pc_r[PW-1:0]], 1'b1);
            if (cnt_r == LAST_C) begin
               cnt_next_s = {HW{1'b0}};
               pc_next_s  = pc_inc_s;
               if (pc_inc_s < count_r) begin
                  // fields only change here, while cpu clk falls back to 0
                  state_next_s = SETUP;
                  pins_next_s  = entry_pins(mem_r[pc_inc_s[PW-1:0]], 1'b0);
               end else begin
                  state_next_s = CAPTURE;
                  pins_next_s  = 8'h00;
                  done_next_s  = 1'b1;
                  rv_next_s    = 1'b1;
                  capture_s    = 1'b1;
               end
            end else begin
               cnt_next_s = cnt_r + HW'(1);
            end
         end

         CAPTURE: begin
            state_next_s = IDLE;
            pc_next_s    = {CW{1'b0}};
            pins_next_s  = 8'h00;
         end

         default: begin
            state_next_s = IDLE;
            cnt_next_s   = {HW{1'b0}};
            pc_next_s    = {CW{1'b0}};
            pins_next_s  = 8'h00;
         end
      endcase
   end

   // State, counters and registered outputs; reset aborts any run silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= {HW{1'b0}};
         pc_r       <= {CW{1'b0}};
         count_r    <= {CW{1'b0}};
         pins_r     <= 8'h00;
         result_r   <= 8'h00;
         done_r     <= 1'b0;
         rv_r       <= 1'b0;
         busy_r     <= 1'b0;
         wr_ready_r <= 1'b1;
      end else begin
         state_r    <= state_next_s;
         cnt_r      <= cnt_next_s;
         pc_r       <= pc_next_s;
         count_r    <= count_next_s;
         pins_r     <= pins_next_s;
         done_r     <= done_next_s;
         rv_r       <= rv_next_s;
         busy_r     <= (state_next_s != IDLE);
         wr_ready_r <= (state_next_s == IDLE) && (count_next_s < DEPTH_C);
         if (capture_s) begin
            result_r <= cpu_out;
         end else begin
            result_r <= result_r;
         end
      end
   end

endmodule

// File: doc/hidden_cpu_driver.md
HIDDEN_CPU_DRIVER -- requirements
Module: hidden_cpu_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of program entries (power of two, 2..64).
REQ-002 SHALL have parameter HALF, default 2, meaning clk cycles per CPU-clock half-period (>=1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_valid  input  1  program-entry write request.
REQ-006 SHALL have port wr_data  input  6  entry: [1:0] opcode, [3:2] reg0Addr, [5:4] reg1Addr.
REQ-007 SHALL have port wr_ready  output  1  entry accepted when wr_valid && wr_ready.
REQ-008 SHALL have port clear  input  1  empties the program store (IDLE only).
REQ-009 SHALL have port start  input  1  begins a run (IDLE only).
REQ-010 SHALL have port busy  output  1  high while a run is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-012 SHALL have port prog_count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have port cpu_pins  output  8  drives CPU pin bus: [0] cpu clk, [1] cpu rst, [3:2] opcode, [5:4] reg0Addr, [7:6] reg1Addr.
REQ-014 SHALL have port cpu_out  input  8  CPU result bus.
REQ-015 SHALL have port result  output  8  cpu_out captured at end of run.
REQ-016 SHALL have port result_valid  output  1  one-cycle pulse, coincident with done.

Function
REQ-017 SHALL implement states IDLE, RST_CPU, SETUP, CLK_HI, CAPTURE.
REQ-018 SHALL assert wr_ready = (state==IDLE) && (prog_count<DEPTH); accepted entry is stored at index prog_count, prog_count increments.
REQ-019 SHALL ignore wr_valid when store full (prog_count==DEPTH); no wrap, no overwrite.
REQ-020 SHALL, on clear in IDLE, set prog_count to 0; clear has priority over start and over a write in the same cycle.
REQ-021 SHALL, on start in IDLE with prog_count==0, skip the run: pulse done for one cycle next cycle; result, result_valid and cpu_pins unchanged.
REQ-022 SHALL, on start in IDLE with prog_count>0, enter RST_CPU next cycle; busy=1 from RST_CPU through CAPTURE.
REQ-023 SHALL, for a write and start in the same IDLE cycle, accept the write and include it in the run.
REQ-024 SHALL, in RST_CPU, drive cpu_pins=8'h02 (cpu rst=1, cpu clk=0) for HALF cycles, then enter SETUP with pc=0.
REQ-025 SHALL, in SETUP, drive entry[pc] fields onto cpu_pins[7:2] with cpu clk=0 and cpu rst=0 for HALF cycles, then enter CLK_HI.
REQ-026 SHALL, in CLK_HI, hold the same fields with cpu clk=1 for HALF cycles; on exit, pc increments and next state is SETUP if pc+1<prog_count, else CAPTURE.
REQ-027 SHALL keep cpu_pins[7:2] stable across each SETUP/CLK_HI pair (fields change only while cpu clk=0).
REQ-028 SHALL, in CAPTURE (one cycle), drive cpu_pins=8'h00, register cpu_out into result, pulse done and result_valid, and return to IDLE.
REQ-029 SHALL make the run length exactly 1+HALF+2*HALF*N cycles from the start-sampling edge to the done cycle, N=prog_count.
REQ-030 SHALL ignore start, clear and wr_valid while busy.
REQ-031 SHALL retain program contents and prog_count after a run (rerun without reload).
REQ-032 SHALL drive cpu_pins=8'h00 in IDLE.
REQ-033 SHALL register all outputs (no combinational path from inputs to cpu_pins).

Reset
REQ-034 SHALL, on rst, asynchronously force state=IDLE, pc=0, prog_count=0, cpu_pins=8'h00, result=8'h00, busy=0, done=0, result_valid=0; wr_ready=1 from the first cycle after rst release.
REQ-035 SHALL abort any run on mid-run rst with no done or result_valid pulse; stored entries need not be cleared but are unreachable (prog_count=0).

Verification
REQ-036 SHALL cover: HALF=2, write 3 entries, start at t -> cpu_pins=02 for t+1..t+2, three clk pulses each 2 low/2 high, done and result_valid at t+15, result=cpu_out sampled then.
REQ-037 SHALL cover: write DEPTH entries then one more with wr_valid=1 -> wr_ready=0, prog_count stays DEPTH, entry 0 unchanged.
REQ-038 SHALL cover: start with empty store -> done pulse at t+1, busy never 1, cpu_pins stays 00.
REQ-039 SHALL cover: clear+start+wr_valid in same IDLE cycle -> prog_count=0, no run, no write.
REQ-040 SHALL cover: rst asserted in CLK_HI -> cpu_pins=00 immediately, no done, prog_count=0, wr_ready=1 after release.
REQ-041 SHALL cover: entry opcode=2'b10, reg0=2'b01, reg1=2'b11 -> cpu_pins=8'hD8 in SETUP, 8'hD9 in CLK_HI.
